// File: rtl/inst_fetch_unit_pkg.sv
// Shared fetch-side types and MIPS opcode/funct constants.
// Also used by the decode controller.
package inst_fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] F_JR     = 6'h08;
  localparam logic [5:0] F_JALR   = 6'h09;
  localparam logic [5:0] F_ADD    = 6'h20;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DRAIN
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/inst_fetch_unit_fifo.sv
// Synchronous FIFO of fetched {pc, inst} entries.
// Registered head: a push becomes visible the cycle after.
module inst_fetch_unit_fifo
  import inst_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic [AW:0]  count
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = wdata;
        wr_d        = wr_q + AW'(1);
      end
      if (pop) begin
        rd_d = rd_q + AW'(1);
      end
      cnt_d = cnt_q + {{AW{1'b0}}, push}
                    - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign rdata = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: PC, imem req/ack FSM, fetch buffer,
// and decode-side valid/ready presentation.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [5:0]  id_opcode,
  output logic [5:0]  id_funct,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] CNT_MAX = (AW+1)'(FIFO_DEPTH);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;
  logic         req_q, req_d;

  logic [AW:0]  count;
  logic [AW:0]  occ;
  fetch_entry_t head;
  fetch_entry_t wentry;
  logic         push, pop, flush, space;

  assign flush  = redirect_valid;
  assign id_valid = (count != '0);
  assign pop    = id_valid & id_ready & ~flush;
  assign push   = (state_q == S_WAIT) & imem_ack & ~flush;
  assign occ    = count - {{AW{1'b0}}, pop};
  // Only issue when a slot is guaranteed for the returning word.
  assign space  = flush | (occ < CNT_MAX);
  assign wentry = '{pc: addr_q, inst: imem_rdata};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    req_d   = req_q;
    if (push) pc_d = pc_q + 32'd4;
    if (flush) pc_d = align_pc(redirect_pc);
    case (state_q)
      S_IDLE: begin
        if (space) begin
          req_d   = 1'b1;
          addr_d  = pc_d;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          req_d   = 1'b0;
          state_d = S_IDLE;
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (imem_ack) begin
          req_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
    end
  end

  inst_fetch_unit_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (wentry),
    .rdata (head),
    .count (count)
  );

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign id_inst     = head.inst;
  assign id_opcode   = head.inst[31:26];
  assign id_funct    = head.inst[5:0];
  assign id_pc       = head.pc;
  assign id_pc_plus4 = head.pc + 32'd4;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: memory responder, random flow
// control and redirects, scoreboard of expected program order.
module tb_inst_fetch_unit;

  localparam logic [31:0] RPC = 32'h0040_0000;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [5:0]  id_opcode;
  logic [5:0]  id_funct;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;

  inst_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_inst        (id_inst),
    .id_opcode      (id_opcode),
    .id_funct       (id_funct),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int pops = 0;
  int ack_count = 0;
  int force_delay = -1;
  int max_delay = 3;
  logic [31:0] exp_q[$];
  logic        first_pending = 1'b0;
  logic [31:0] first_addr = '0;
  logic [5:0]  first_op = 6'h3F;
  logic [5:0]  first_fn = 6'h3F;
  logic [31:0] wrap_p4 = 32'h1;
  logic        saw_zero = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == RPC) return 32'h012A_4020;
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  task automatic check(input string name, input logic ok,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %h expected %h @%0t",
               name, act, exp, $time);
    end
  endtask

  // Program order from a start address: sequential words.
  task automatic restart(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 1024; i++)
      exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_redirect(input logic [31:0] t);
    redirect_pc    = t;
    redirect_valid = 1'b1;
    restart(t & 32'hFFFF_FFFC);
    cyc();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_pops(input int n, input int budget,
                           input string name);
    int start;
    int k;
    start = pops;
    k = 0;
    while (pops - start < n && k < budget) begin
      cyc();
      k++;
    end
    check(name, pops - start >= n,
          32'(pops - start), 32'(n));
  endtask

  // Memory responder: random or forced ack delay per request.
  initial begin
    logic        in_req;
    logic [31:0] req_addr;
    int          wcnt;
    in_req = 1'b0;
    req_addr = '0;
    wcnt = 0;
    imem_ack = 1'b0;
    imem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        imem_ack = 1'b0;
        in_req = 1'b0;
      end else if (imem_req) begin
        if (!in_req) begin
          in_req = 1'b1;
          req_addr = imem_addr;
          wcnt = (force_delay >= 0) ? force_delay
               : int'($urandom_range(max_delay, 0));
          check("addr_align", imem_addr[1:0] == 2'b00,
                imem_addr, imem_addr & 32'hFFFF_FFFC);
          if (first_pending) begin
            check("first_addr", imem_addr == first_addr,
                  imem_addr, first_addr);
            first_pending = 1'b0;
          end
        end else begin
          check("addr_stable", imem_addr == req_addr,
                imem_addr, req_addr);
        end
        if (wcnt == 0) begin
          imem_ack = 1'b1;
          imem_rdata = mem_word(imem_addr);
          in_req = 1'b0;
          ack_count++;
        end else begin
          imem_ack = 1'b0;
          imem_rdata = $urandom;
          wcnt--;
        end
      end else begin
        imem_ack = 1'b0;
        in_req = 1'b0;
      end
    end
  end

  // Monitor: compares every decode handshake with the queue.
  initial begin
    logic        hold;
    logic        pop_now;
    logic [31:0] h_pc, h_inst, ep, ei;
    hold = 1'b0;
    h_pc = '0;
    h_inst = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold = 1'b0;
      end else begin
        if (hold)
          check("id_hold",
                id_valid && id_pc == h_pc && id_inst == h_inst,
                id_pc, h_pc);
        pop_now = id_valid && id_ready && !redirect_valid;
        if (pop_now) begin
          if (exp_q.size() == 0) begin
            check("id_extra", 1'b0, id_pc, 32'h0);
          end else begin
            ep = exp_q.pop_front();
            ei = mem_word(ep);
            check("id_pc", id_pc == ep, id_pc, ep);
            check("id_fields",
                  id_inst == ei && id_opcode == ei[31:26] &&
                  id_funct == ei[5:0] &&
                  id_pc_plus4 == ep + 32'd4,
                  id_inst, ei);
            pops++;
            if (id_pc == RPC) begin
              first_op = id_opcode;
              first_fn = id_funct;
            end
            if (id_pc == 32'hFFFF_FFFC) wrap_p4 = id_pc_plus4;
            if (id_pc == 32'h0) saw_zero = 1'b1;
          end
        end
        hold = id_valid && !pop_now && !redirect_valid;
        h_pc = id_pc;
        h_inst = id_inst;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, id_valid == 1'b0, 32'(id_valid), 0);
    check({tag, "_req"}, imem_req == 1'b0, 32'(imem_req), 0);
    check({tag, "_addr"}, imem_addr == RPC, imem_addr, RPC);
    check({tag, "_pc"}, id_pc == 32'h0, id_pc, 0);
    check({tag, "_inst"},
          id_inst == 0 && id_opcode == 0 && id_funct == 0,
          id_inst, 0);
    check({tag, "_pc4"}, id_pc_plus4 == 32'd4, id_pc_plus4, 4);
  endtask

  initial begin
    int base, k;
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    id_ready = 1'b0;
    #1;
    check_reset_outputs("rst");
    restart(RPC);
    first_pending = 1'b1;
    first_addr = RPC;
    cyc();
    cyc();
    reset = 1'b0;

    // Sequential fetch, ack one cycle after req.
    force_delay = 1;
    id_ready = 1'b1;
    wait_pops(8, 100, "t1_pops");
    check("t1_opcode", first_op == 6'h00, 32'(first_op), 0);
    check("t1_funct", first_fn == 6'h20, 32'(first_fn), 32'h20);

    // Backpressure from an empty buffer.
    force_delay = 0;
    k = 0;
    while (imem_req && k < 20) begin cyc(); k++; end
    check("t2_idle", !imem_req, 32'(imem_req), 0);
    id_ready = 1'b0;
    base = ack_count;
    do_redirect(32'h0040_0200);
    repeat (12) cyc();
    check("t2_acks", ack_count - base == 2,
          32'(ack_count - base), 2);
    check("t2_req_low", !imem_req, 32'(imem_req), 0);
    check("t2_valid", id_valid, 32'(id_valid), 1);
    check("t2_head", id_pc == 32'h0040_0200,
          id_pc, 32'h0040_0200);
    id_ready = 1'b1;
    wait_pops(4, 60, "t2_drain");

    // Redirect while waiting, ack three cycles later.
    force_delay = 3;
    k = 0;
    while (!(imem_req && !imem_ack) && k < 30) begin
      cyc(); k++;
    end
    check("t3_inwait", imem_req && !imem_ack,
          32'(imem_req), 1);
    do_redirect(32'h0040_0100);
    check("t3_drain_req", imem_req, 32'(imem_req), 1);
    wait_pops(3, 80, "t3_pops");

    // Redirect together with ack and pop.
    force_delay = 0;
    id_ready = 1'b0;
    do_redirect(32'h0040_0300);
    k = 0;
    while (!(imem_req && imem_ack && id_valid) && k < 20) begin
      cyc(); k++;
    end
    check("t4_setup", imem_req && imem_ack && id_valid,
          32'(id_valid), 1);
    id_ready = 1'b1;
    do_redirect(32'h0040_0103);
    check("t4_empty", !id_valid, 32'(id_valid), 0);
    check("t4_idle", !imem_req, 32'(imem_req), 0);
    cyc();
    check("t4_req", imem_req && imem_addr == 32'h0040_0100,
          imem_addr, 32'h0040_0100);
    wait_pops(3, 40, "t4_pops");

    // PC wraparound.
    force_delay = -1;
    do_redirect(32'hFFFF_FFF4);
    wait_pops(5, 80, "t5_pops");
    check("t5_wrap_pc4", wrap_p4 == 32'h0, wrap_p4, 0);
    check("t5_zero", saw_zero, 32'(saw_zero), 1);

    // Reset while a request is outstanding and data is held.
    force_delay = 20;
    id_ready = 1'b0;
    k = 0;
    while (!(id_valid && imem_req) && k < 40) begin
      cyc(); k++;
    end
    check("t6_setup", id_valid && imem_req,
          32'(id_valid), 1);
    reset = 1'b1;
    #1;
    check_reset_outputs("t6");
    restart(RPC);
    first_pending = 1'b1;
    first_addr = RPC;
    cyc();
    cyc();
    reset = 1'b0;
    force_delay = -1;
    id_ready = 1'b1;
    wait_pops(3, 40, "t6_pops");

    // Random flow control and redirects.
    for (int c = 0; c < 1500; c++) begin
      id_ready = ($urandom_range(3, 0) != 0);
      if ($urandom_range(24, 0) == 0)
        do_redirect($urandom);
      else
        cyc();
    end
    id_ready = 1'b1;
    wait_pops(2, 40, "final_pops");

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
